// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode map, control states and the
// sub-opcode handed to the iterative multiply/divide unit.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00,
    OP_AND   = 5'h01,
    OP_OR    = 5'h02,
    OP_SLL   = 5'h03,
    OP_SLTU  = 5'h04,
    OP_SRL   = 5'h05,
    OP_SUB   = 5'h06,
    OP_XOR   = 5'h07,
    OP_BEQ   = 5'h08,
    OP_BNE   = 5'h09,
    OP_BLTU  = 5'h0A,
    OP_BGEU  = 5'h0B,
    OP_SLT   = 5'h0C,
    OP_SRA   = 5'h0D,
    OP_BLT   = 5'h0E,
    OP_BGE   = 5'h0F,
    OP_MUL   = 5'h10,
    OP_MULHU = 5'h11,
    OP_DIVU  = 5'h12,
    OP_REMU  = 5'h13
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_e;

  // Low two opcode bits of the 0x10-0x13 group select the iterative operation.
  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

  function automatic logic is_iter_op(input logic [4:0] opcode);
    return opcode[4:2] == 3'b100;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide: one shift-add or one restoring-subtract
// step per cycle, WIDTH steps per operation, sharing one hi/lo register pair.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  md_op_e           md_op;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [CW-1:0]    count;
  logic             running;

  logic [WIDTH-1:0] addend, hi_next, lo_next;
  logic [WIDTH:0]   sum, shifted;
  logic             ge, is_div;

  // Multiply: {hi,lo} is the product shifting right, lo starts as the multiplier.
  // Divide: hi is the partial remainder, lo shifts the dividend out and the
  // quotient in. A zero divisor always "fits", giving all-ones and rem = A.
  // NOTE: every variable in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_div  = (md_op == MD_DIVU) || (md_op == MD_REMU);
    addend  = lo[0] ? opnd : '0;
    sum     = {1'b0, hi} + {1'b0, addend};
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      hi_next = ge ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], ge};
    end
  end

  // done marks the cycle whose edge performs the final step; res is that step's outcome.
  assign done = running && (count == CW'(WIDTH - 1));
  assign res  = ((md_op == MD_MUL) || (md_op == MD_DIVU)) ? lo_next : hi_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_op   <= MD_MUL;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      md_op   <= op;
      hi      <= '0;
      lo      <= a;
      opnd    <= b;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      hi    <= hi_next;
      lo    <= lo_next;
      count <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus iterative
// MUL/MULHU/DIVU/REMU behind a valid/ready handshake on both sides.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_e           state, state_next;
  logic             alive, accept, iter_op, md_start, md_done;
  logic [WIDTH-1:0] alu_res, md_res;
  logic [SHW-1:0]   shamt;

  assign shamt   = b[SHW-1:0];
  assign iter_op = is_iter_op(operation);
  assign accept  = in_valid && in_ready;

  // Branch opcodes return 0 when the branch is taken, so each is the inverted condition.
  always_comb begin
    alu_res = '0;
    case (operation)
      OP_ADD:  alu_res = a + b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_SRL:  alu_res = a >> shamt;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_BEQ:  alu_res = WIDTH'(a != b);
      OP_BNE:  alu_res = WIDTH'(a == b);
      OP_BLTU: alu_res = WIDTH'(a >= b);
      OP_BGEU: alu_res = WIDTH'(a < b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_BLT:  alu_res = WIDTH'($signed(a) >= $signed(b));
      OP_BGE:  alu_res = WIDTH'($signed(a) < $signed(b));
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (md_op_e'(operation[1:0])),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res)
  );

  always_comb begin
    state_next = state;
    md_start   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (iter_op) begin
            state_next = ST_ITER;
            md_start   = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_ITER: if (md_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // alive keeps in_ready low while reset is held and raises it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      alive  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      alive <= 1'b1;
      if (accept && !iter_op) result <= alu_res;
      else if (state == ST_ITER && md_done) result <= md_res;
    end
  end

  assign in_ready  = alive && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ITER);
  assign zero      = (result == '0);

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning the number of operand-B low bits used as the shift amount.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1, meaning A, B and OPERATION are valid this cycle.
REQ-006 SHALL have port IN_READY, output, 1, meaning the block can accept an operation.
REQ-007 SHALL have port A, input, WIDTH, operand A.
REQ-008 SHALL have port B, input, WIDTH, operand B.
REQ-009 SHALL have port OPERATION, input, 5, the opcode.
REQ-010 SHALL have port OUT_VALID, output, 1, meaning RESULT and ZERO hold a completed result.
REQ-011 SHALL have port OUT_READY, input, 1, meaning the consumer takes the result this cycle.
REQ-012 SHALL have port RESULT, output, WIDTH, the registered result.
REQ-013 SHALL have port ZERO, output, 1, high iff RESULT == 0.
REQ-014 SHALL have port BUSY, output, 1, high while an iterative operation is in progress.

Function
REQ-015 SHALL decode opcodes 0x00-0x07 as ADD, AND, OR, SLL, SLTU, SRL, SUB and XOR, all modulo 2^WIDTH; shifts SHALL use B[SHW-1:0].
REQ-016 SHALL decode 0x08-0x0B as BEQ, BNE, BLTU and BGEU: RESULT = 0 when the condition holds, else 1, so ZERO = take-branch.
REQ-017 SHALL decode 0x0C as SLT (signed), 0x0D as SRA (arithmetic), 0x0E as BLT (signed) and 0x0F as BGE (signed).
REQ-018 SHALL decode 0x10 as MUL (low WIDTH bits of the product), 0x11 as MULHU (high WIDTH bits, unsigned), 0x12 as DIVU and 0x13 as REMU.
REQ-019 SHALL return RESULT = 0 for undefined opcodes, completing with single-cycle latency.
REQ-020 SHALL accept an operation only on a cycle where IN_VALID && IN_READY, and SHALL assert IN_READY only in state IDLE.
REQ-021 SHALL implement the states IDLE, ITER and DONE.
REQ-022 SHALL move IDLE->DONE on acceptance of a single-cycle opcode, so OUT_VALID rises on the next cycle (latency 1).
REQ-023 SHALL move IDLE->ITER on acceptance of an opcode in 0x10-0x13, latching the operands and clearing a step counter.
REQ-024 SHALL, in ITER, perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle, and SHALL move to DONE after exactly WIDTH steps, giving latency WIDTH+1.
REQ-025 SHALL, for DIVU with B == 0, return all-ones; for REMU with B == 0, return A; both with normal iterative latency.
REQ-026 SHALL hold RESULT, ZERO and OUT_VALID stable in DONE until OUT_READY, then return to IDLE.
REQ-027 SHALL NOT accept a new operation in the DONE->IDLE cycle, even if OUT_READY and IN_VALID are both high (no bypass; throughput is at most one operation per two cycles).
REQ-028 SHALL ignore input changes while in ITER or DONE.
REQ-029 SHALL assert BUSY if and only if the state is ITER.

Reset
REQ-030 SHALL, while RST_N is low, force state IDLE, IN_READY = 0, OUT_VALID = 0, BUSY = 0, RESULT = 0, ZERO = 1 and step counter = 0.
REQ-031 SHALL abandon any in-flight ITER operation when reset is asserted, with no result emitted.
REQ-032 SHALL assert IN_READY on the first clock edge after RST_N deasserts.

Structure
REQ-033 SHALL take the opcode enum (op_e, 5 bits), the WIDTH default and the state enum from the shared package alu_pkg.
REQ-034 SHALL place the iterative multiply/divide datapath (accumulator, shift register, step counter) in the sub-module alu_muldiv_iter, with start/done handshaking to the parent FSM.

Verification
REQ-035 SHALL verify, with WIDTH=32: ADD 0xFFFFFFFF + 1 -> RESULT 0, ZERO 1, OUT_VALID exactly one cycle after acceptance.
REQ-036 SHALL verify: SRA 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000; BLT -1 vs 1 -> RESULT 0; BLTU -1 vs 1 -> RESULT 1.
REQ-037 SHALL verify: MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001 and MULHU -> 0xFFFFFFFE, each with OUT_VALID at cycle 33 after acceptance and BUSY high for 32 cycles.
REQ-038 SHALL verify: DIVU 100/7 -> 14; REMU -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-039 SHALL verify: OUT_READY held low for 10 cycles -> RESULT and OUT_VALID stable and IN_READY low; on release, IN_READY high the following cycle.
REQ-040 SHALL verify: RST_N pulsed low at ITER step 15 of a DIVU -> immediate IDLE with OUT_VALID 0, and a following ADD 2+3 -> 5.
